// File: rtl/alu_div_seq.sv
// alu_div_seq: sequential restoring radix-2 divider / remainder unit for EX.
//
// Operators (operator_i): 00 DIVU, 01 DIV, 10 REMU, 11 REM.
// One shift-subtract step per cycle on the operand magnitudes, followed by
// a single sign-correction / result-select cycle. The result is held under
// back-pressure until the EX stage consumes it with ex_ready_i.
//
// Optional feature macro: ALU_DIV_EARLY_OUT_EN
//   When defined, trivial operations (divisor zero, signed overflow,
//   |a| < |b|) skip the iteration loop and present their result one cycle
//   after acceptance. When undefined, every operation takes WIDTH+1 cycles.
//   Special-case results are identical in both builds.

module alu_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             core_clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [1:0]       operator_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             ex_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             busy_o
);

    // FSM encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // Number of shift-subtract steps for a full-width division
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    // Most-negative two's complement value of the operand width
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             is_rem_q,    is_rem_d;
    logic             neg_quot_q,  neg_quot_d;
    logic             neg_rem_q,   neg_rem_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [WIDTH-1:0] quot_q,      quot_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             ready_q,     ready_d;

    // ------------------------------------------------------------------
    // Acceptance-side operand conditioning
    // ------------------------------------------------------------------
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Early-out decision (constant zero when the feature is compiled out)
    logic             early_hit;
    logic             early_ovf;

    // Iteration datapath
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             step_ok;

    // Sign-corrected final values
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] final_res;

    logic             accept;

    // Convert live operands to magnitudes and note which ones were negative.
    // The magnitude of MOST_NEG is itself, which reads correctly as unsigned.
    always_comb begin
        op_signed = operator_i[0];
        a_neg     = op_signed & operand_a_i[WIDTH-1];
        b_neg     = op_signed & operand_b_i[WIDTH-1];
        b_zero    = (operand_b_i == '0);
        a_abs     = a_neg ? -operand_a_i : operand_a_i;
        b_abs     = b_neg ? -operand_b_i : operand_b_i;
    end

`ifdef ALU_DIV_EARLY_OUT_EN
    // Detect operations whose result is known without iterating.
    always_comb begin
        early_ovf = op_signed && (operand_a_i == MOST_NEG) && (operand_b_i == '1);
        early_hit = b_zero | early_ovf | (a_abs < b_abs);
    end
`else
    // Early-out compiled out: every operation walks the full loop.
    assign early_ovf = 1'b0;
    assign early_hit = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the difference only if it did not borrow.
    always_comb begin
        partial = {rem_q, quot_q[WIDTH-1]};
        trial   = partial - {1'b0, divisor_q};
        step_ok = ~trial[WIDTH];
    end

    // Sign-correct the magnitudes and pick quotient or remainder.
    always_comb begin
        quot_fix  = neg_quot_q ? -quot_q : quot_q;
        rem_fix   = neg_rem_q  ? -rem_q  : rem_q;
        final_res = is_rem_q ? rem_fix : quot_fix;
    end

    // Next-state logic for the FSM and the iteration registers.
    // Acceptance is shared between IDLE and the consumption cycle of FINISH
    // so back-to-back operations skip IDLE entirely. Trivial operations are
    // loaded with their final magnitudes and a zero counter, so the next
    // cycle goes straight to FINISH through the normal correction path.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                accept = enable_i;
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d  = FINISH;
                    ready_d  = 1'b1;
                    result_d = final_res;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    rem_d  = step_ok ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], step_ok};
                end
            end
            FINISH: begin
                if (ex_ready_i) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                    accept  = enable_i;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase

        if (accept) begin
            state_d   = CALC;
            ready_d   = 1'b0;
            is_rem_d  = operator_i[1];
            // Divide-by-zero quotient stays all-ones regardless of signs
            neg_quot_d = (a_neg ^ b_neg) & ~b_zero;
            neg_rem_d  = a_neg;
            divisor_d  = b_abs;
            if (early_hit) begin
                cnt_d = '0;
                if (b_zero) begin
                    quot_d = '1;
                    rem_d  = a_abs;
                end else if (early_ovf) begin
                    quot_d = a_abs;
                    rem_d  = '0;
                end else begin
                    quot_d = '0;
                    rem_d  = a_abs;
                end
            end else begin
                cnt_d  = CNT_LOAD;
                quot_d = a_abs;
                rem_d  = '0;
            end
        end
    end

    // State registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q != IDLE);

endmodule
